// File: rtl/trap_pkg.sv
// Shared types and constants for the machine-mode trap controller.
// Optional WFI support is enabled with `define TRAP_WFI_EN.
package trap_pkg;

    localparam int XLEN          = 32;
    localparam int MAX_LOCAL_IRQ = 15;

    localparam logic [4:0] CAUSE_MSI   = 5'd3;
    localparam logic [4:0] CAUSE_MTI   = 5'd7;
    localparam logic [4:0] CAUSE_MEI   = 5'd11;
    localparam logic [4:0] CAUSE_LOCAL = 5'd16;

    typedef enum logic [1:0] {
        IDLE,
        FLUSH,
        COMMIT
`ifdef TRAP_WFI_EN
        , WFI
`endif
    } state_t;

    typedef enum logic [1:0] {
        K_EXC,
        K_IRQ,
        K_MRET
    } kind_t;

    function automatic logic [4:0] local_code(input int i);
        return CAUSE_LOCAL + 5'(i);
    endfunction

endpackage

// File: rtl/trap_irq_arb.sv
// Fixed-priority interrupt arbiter: MEI > MSI > MTI > local (low index wins).
// Ports: irq_vec (pending & enabled), glob_en (mstatus.mie) -> pending, code, is_interrupt.
module trap_irq_arb
    import trap_pkg::*;
#(
    parameter int NUM_LOCAL_IRQ = 4
) (
    input  logic [16+NUM_LOCAL_IRQ-1:0] irq_vec,
    input  logic                        glob_en,
    output logic                        pending,
    output logic [4:0]                  code,
    output logic                        is_interrupt
);

    always_comb begin
        code = '0;
        // Walk locals high-to-low so the lowest index is written last.
        for (int i = NUM_LOCAL_IRQ - 1; i >= 0; i--) begin
            if (irq_vec[16+i]) code = local_code(i);
        end
        // Standard sources override locals, highest priority last.
        if (irq_vec[CAUSE_MTI]) code = CAUSE_MTI;
        if (irq_vec[CAUSE_MSI]) code = CAUSE_MSI;
        if (irq_vec[CAUSE_MEI]) code = CAUSE_MEI;
    end

    assign pending      = |irq_vec;
    assign is_interrupt = pending & glob_en;

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap controller: latches exceptions, interrupts and MRET,
// drains the pipeline, then issues a one-cycle redirect plus CSR update strobe.
// Ports: retire-stage event inputs, flush handshake, redirect and CSR write
// outputs, registered csr_mip. Optional WFI state enabled by `define TRAP_WFI_EN.
module trap_ctrl
    import trap_pkg::*;
#(
    parameter int NUM_LOCAL_IRQ = 4
) (
    input  logic                        clk,
    input  logic                        rst_b,
    input  logic                        valid,
    input  logic [XLEN-1:0]             pc,
    input  logic                        exc_pending,
    input  logic [3:0]                  exc_code,
    input  logic [XLEN-1:0]             exc_tval,
    input  logic                        mret,
    input  logic                        wfi,
    input  logic [2:0]                  std_irq,
    input  logic [NUM_LOCAL_IRQ-1:0]    local_irq,
    output logic                        flush_req,
    input  logic                        flush_ack,
    output logic                        stall,
    output logic                        trap,
    output logic [XLEN-1:0]             trap_pc,
    output logic                        ent_trap,
    output logic                        ext_trap,
    output logic [1:0]                  csr_wr_mstatus,
    output logic [XLEN-1:0]             csr_wr_mepc,
    output logic [XLEN-1:0]             csr_wr_mcause,
    output logic [XLEN-1:0]             csr_wr_mtval,
    output logic [16+NUM_LOCAL_IRQ-1:0] csr_mip,
    input  logic [1:0]                  csr_rd_mstatus,
    input  logic [16+NUM_LOCAL_IRQ-1:0] csr_rd_mie,
    input  logic [XLEN-1:0]             csr_rd_mtvec,
    input  logic [XLEN-1:0]             csr_rd_mepc
);

    localparam int MIP_W = 16 + NUM_LOCAL_IRQ;

    state_t            state_q, state_d;
    kind_t             kind_q, kind_d;
    logic [XLEN-1:0]   epc_q, epc_d;
    logic [XLEN-1:0]   tval_q, tval_d;
    logic [4:0]        code_q, code_d;
    logic              lat_en;
    logic [MIP_W-1:0]  mip_q, mip_d;
    logic              arb_pending;
    logic              arb_take;
    logic [4:0]        arb_code;
    logic [XLEN-1:0]   tvec_base;
    logic [XLEN-1:0]   vec_off;

`ifndef TRAP_WFI_EN
    logic unused_wfi;
    assign unused_wfi = wfi;
`endif

    always_comb begin
        mip_d                 = '0;
        mip_d[CAUSE_MSI]      = std_irq[0];
        mip_d[CAUSE_MTI]      = std_irq[1];
        mip_d[CAUSE_MEI]      = std_irq[2];
        mip_d[MIP_W-1:16]     = local_irq;
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) mip_q <= '0;
        else        mip_q <= mip_d;
    end

    assign csr_mip = mip_q;

    trap_irq_arb #(
        .NUM_LOCAL_IRQ (NUM_LOCAL_IRQ)
    ) u_arb (
        .irq_vec      (mip_q & csr_rd_mie),
        .glob_en      (csr_rd_mstatus[0]),
        .pending      (arb_pending),
        .code         (arb_code),
        .is_interrupt (arb_take)
    );

    always_comb begin
        state_d = state_q;
        lat_en  = 1'b0;
        kind_d  = K_EXC;
        epc_d   = pc;
        code_d  = {1'b0, exc_code};
        tval_d  = exc_tval;
        unique case (state_q)
            IDLE: begin
                if (valid & exc_pending) begin
                    lat_en  = 1'b1;
                    state_d = FLUSH;
                end else if (valid & arb_take) begin
                    lat_en  = 1'b1;
                    kind_d  = K_IRQ;
                    code_d  = arb_code;
                    tval_d  = '0;
                    state_d = FLUSH;
                end else if (valid & mret) begin
                    lat_en  = 1'b1;
                    kind_d  = K_MRET;
                    code_d  = '0;
                    tval_d  = '0;
                    state_d = FLUSH;
                end
`ifdef TRAP_WFI_EN
                else if (valid & wfi) begin
                    // Resume point is the instruction after the WFI.
                    lat_en  = 1'b1;
                    epc_d   = pc + XLEN'(4);
                    code_d  = '0;
                    tval_d  = '0;
                    state_d = WFI;
                end
`endif
            end
            FLUSH: begin
                if (flush_ack) state_d = COMMIT;
            end
            COMMIT: begin
                state_d = IDLE;
            end
`ifdef TRAP_WFI_EN
            WFI: begin
                // Wake on any enabled pending source; trap only if mie=1.
                if (arb_pending) begin
                    if (csr_rd_mstatus[0]) begin
                        lat_en  = 1'b1;
                        kind_d  = K_IRQ;
                        epc_d   = epc_q;
                        code_d  = arb_code;
                        tval_d  = '0;
                        state_d = FLUSH;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= IDLE;
            kind_q  <= K_EXC;
            epc_q   <= '0;
            code_q  <= '0;
            tval_q  <= '0;
        end else begin
            state_q <= state_d;
            if (lat_en) begin
                kind_q <= kind_d;
                epc_q  <= epc_d;
                code_q <= code_d;
                tval_q <= tval_d;
            end
        end
    end

    assign tvec_base = {csr_rd_mtvec[XLEN-1:2], 2'b00};
    assign vec_off   = (kind_q == K_IRQ && csr_rd_mtvec[1:0] == 2'b01)
                     ? XLEN'({code_q, 2'b00}) : '0;

    always_comb begin
        flush_req      = (state_q == FLUSH);
`ifdef TRAP_WFI_EN
        stall          = (state_q == WFI);
`else
        stall          = 1'b0;
`endif
        trap           = 1'b0;
        trap_pc        = '0;
        ent_trap       = 1'b0;
        ext_trap       = 1'b0;
        csr_wr_mstatus = '0;
        csr_wr_mepc    = '0;
        csr_wr_mcause  = '0;
        csr_wr_mtval   = '0;
        if (state_q == COMMIT) begin
            trap = 1'b1;
            if (kind_q == K_MRET) begin
                ext_trap       = 1'b1;
                trap_pc        = csr_rd_mepc;
                csr_wr_mstatus = {1'b1, csr_rd_mstatus[1]};
            end else begin
                ent_trap                 = 1'b1;
                trap_pc                  = tvec_base + vec_off;
                csr_wr_mstatus           = {csr_rd_mstatus[0], 1'b0};
                csr_wr_mepc              = epc_q;
                csr_wr_mcause[XLEN-1]    = (kind_q == K_IRQ);
                csr_wr_mcause[4:0]       = code_q;
                csr_wr_mtval             = tval_q;
            end
        end
    end

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: vector table of single events plus
// hand sequences for priority, stalled flush, reset abort and WFI.
module tb_trap_ctrl;

    logic        clk = 1'b0;
    logic        rst_b;
    logic        valid;
    logic [31:0] pc;
    logic        exc_pending;
    logic [3:0]  exc_code;
    logic [31:0] exc_tval;
    logic        mret;
    logic        wfi;
    logic [2:0]  std_irq;
    logic [3:0]  local_irq;
    logic        flush_req;
    logic        flush_ack;
    logic        stall;
    logic        trap;
    logic [31:0] trap_pc;
    logic        ent_trap;
    logic        ext_trap;
    logic [1:0]  csr_wr_mstatus;
    logic [31:0] csr_wr_mepc;
    logic [31:0] csr_wr_mcause;
    logic [31:0] csr_wr_mtval;
    logic [19:0] csr_mip;
    logic [1:0]  csr_rd_mstatus;
    logic [19:0] csr_rd_mie;
    logic [31:0] csr_rd_mtvec;
    logic [31:0] csr_rd_mepc;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    trap_ctrl #(.NUM_LOCAL_IRQ(4)) dut (
        .clk            (clk),
        .rst_b          (rst_b),
        .valid          (valid),
        .pc             (pc),
        .exc_pending    (exc_pending),
        .exc_code       (exc_code),
        .exc_tval       (exc_tval),
        .mret           (mret),
        .wfi            (wfi),
        .std_irq        (std_irq),
        .local_irq      (local_irq),
        .flush_req      (flush_req),
        .flush_ack      (flush_ack),
        .stall          (stall),
        .trap           (trap),
        .trap_pc        (trap_pc),
        .ent_trap       (ent_trap),
        .ext_trap       (ext_trap),
        .csr_wr_mstatus (csr_wr_mstatus),
        .csr_wr_mepc    (csr_wr_mepc),
        .csr_wr_mcause  (csr_wr_mcause),
        .csr_wr_mtval   (csr_wr_mtval),
        .csr_mip        (csr_mip),
        .csr_rd_mstatus (csr_rd_mstatus),
        .csr_rd_mie     (csr_rd_mie),
        .csr_rd_mtvec   (csr_rd_mtvec),
        .csr_rd_mepc    (csr_rd_mepc)
    );

    typedef struct {
        logic [31:0] pc;
        logic        exc;
        logic [3:0]  code;
        logic [31:0] tval;
        logic        mret;
        logic [2:0]  std;
        logic [3:0]  loc;
        logic [1:0]  mst;
        logic [19:0] mie;
        logic [31:0] mtvec;
        logic [31:0] mepc;
        logic [31:0] tpc;
        logic        ent;
        logic        ext;
        logic [1:0]  wst;
        logic [31:0] wepc;
        logic [31:0] wcause;
        logic [31:0] wtval;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic nx();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    initial begin
        // pc exc code tval mret std loc mst mie mtvec mepc | tpc ent ext wst wepc wcause wtval
        tbl[0] = '{32'h100, 1'b1, 4'd2, 32'h55, 1'b0, 3'b000, 4'b0000, 2'b01,
                   20'h00000, 32'h801, 32'h0,
                   32'h800, 1'b1, 1'b0, 2'b10, 32'h100, 32'h2, 32'h55};
        tbl[1] = '{32'h300, 1'b0, 4'd0, 32'h0, 1'b0, 3'b110, 4'b0000, 2'b01,
                   20'hFFFFF, 32'h801, 32'h0,
                   32'h82C, 1'b1, 1'b0, 2'b10, 32'h300, 32'h8000000B, 32'h0};
        tbl[2] = '{32'h304, 1'b0, 4'd0, 32'h0, 1'b0, 3'b011, 4'b0000, 2'b01,
                   20'hFFFFF, 32'h801, 32'h0,
                   32'h80C, 1'b1, 1'b0, 2'b10, 32'h304, 32'h80000003, 32'h0};
        tbl[3] = '{32'h308, 1'b0, 4'd0, 32'h0, 1'b0, 3'b010, 4'b1010, 2'b01,
                   20'hFFF7F, 32'h801, 32'h0,
                   32'h844, 1'b1, 1'b0, 2'b10, 32'h308, 32'h80000011, 32'h0};
        tbl[4] = '{32'h30C, 1'b0, 4'd0, 32'h0, 1'b0, 3'b010, 4'b0000, 2'b01,
                   20'hFFFFF, 32'h1000, 32'h0,
                   32'h1000, 1'b1, 1'b0, 2'b10, 32'h30C, 32'h80000007, 32'h0};
        tbl[5] = '{32'h500, 1'b0, 4'd0, 32'h0, 1'b1, 3'b000, 4'b0000, 2'b10,
                   20'h00000, 32'h801, 32'h200,
                   32'h200, 1'b0, 1'b1, 2'b11, 32'h0, 32'h0, 32'h0};
        tbl[6] = '{32'h504, 1'b0, 4'd0, 32'h0, 1'b1, 3'b000, 4'b0000, 2'b01,
                   20'h00000, 32'h801, 32'h1234,
                   32'h1234, 1'b0, 1'b1, 2'b10, 32'h0, 32'h0, 32'h0};
        tbl[7] = '{32'h508, 1'b1, 4'd11, 32'h0, 1'b1, 3'b100, 4'b0000, 2'b00,
                   20'hFFFFF, 32'h801, 32'h0,
                   32'h800, 1'b1, 1'b0, 2'b00, 32'h508, 32'hB, 32'h0};

        rst_b = 1'b0; valid = 1'b0; pc = '0; exc_pending = 1'b0;
        exc_code = '0; exc_tval = '0; mret = 1'b0; wfi = 1'b0;
        std_irq = 3'b111; local_irq = 4'hF; flush_ack = 1'b0;
        csr_rd_mstatus = '0; csr_rd_mie = '0; csr_rd_mtvec = '0;
        csr_rd_mepc = '0;

        smp();
        smp();
        chk("rst_mip", 32'(csr_mip), 32'h0);
        chk("rst_flush_req", 32'(flush_req), 32'h0);
        chk("rst_trap", 32'(trap), 32'h0);
        chk("rst_stall", 32'(stall), 32'h0);
        chk("rst_trap_pc", trap_pc, 32'h0);
        std_irq = '0; local_irq = '0;
        nx();
        rst_b = 1'b1;
        nx();

        for (int i = 0; i < 8; i++) begin
            csr_rd_mstatus = tbl[i].mst;
            csr_rd_mie     = tbl[i].mie;
            csr_rd_mtvec   = tbl[i].mtvec;
            csr_rd_mepc    = tbl[i].mepc;
            std_irq        = tbl[i].std;
            local_irq      = tbl[i].loc;
            nx();
            valid       = 1'b1;
            pc          = tbl[i].pc;
            exc_pending = tbl[i].exc;
            exc_code    = tbl[i].code;
            exc_tval    = tbl[i].tval;
            mret        = tbl[i].mret;
            nx();
            // Scramble inputs: latched values must not follow them.
            valid = 1'b0; exc_pending = 1'b0; mret = 1'b0;
            pc = 32'hDEADBEEC; exc_code = 4'hF; exc_tval = 32'hFFFFFFFF;
            std_irq = '0; local_irq = '0; flush_ack = 1'b1;
            smp();
            chk($sformatf("v%0d_flush_req", i), 32'(flush_req), 32'h1);
            chk($sformatf("v%0d_trap_early", i), 32'(trap), 32'h0);
            nx();
            flush_ack = 1'b0;
            smp();
            chk($sformatf("v%0d_trap", i), 32'(trap), 32'h1);
            chk($sformatf("v%0d_trap_pc", i), trap_pc, tbl[i].tpc);
            chk($sformatf("v%0d_ent", i), 32'(ent_trap), 32'(tbl[i].ent));
            chk($sformatf("v%0d_ext", i), 32'(ext_trap), 32'(tbl[i].ext));
            chk($sformatf("v%0d_mstatus", i), 32'(csr_wr_mstatus),
                32'(tbl[i].wst));
            chk($sformatf("v%0d_mepc", i), csr_wr_mepc, tbl[i].wepc);
            chk($sformatf("v%0d_mcause", i), csr_wr_mcause, tbl[i].wcause);
            chk($sformatf("v%0d_mtval", i), csr_wr_mtval, tbl[i].wtval);
            nx();
            smp();
            chk($sformatf("v%0d_trap_one", i), 32'(trap), 32'h0);
            nx();
        end

        // Exception beats a simultaneous interrupt; interrupt follows.
        csr_rd_mstatus = 2'b01; csr_rd_mie = 20'hFFFFF;
        csr_rd_mtvec = 32'h801; std_irq = 3'b100;
        nx();
        valid = 1'b1; exc_pending = 1'b1; exc_code = 4'd2;
        pc = 32'h600; exc_tval = 32'h0;
        nx();
        exc_pending = 1'b0; pc = 32'h604; flush_ack = 1'b1;
        smp();
        chk("pri_flush_req", 32'(flush_req), 32'h1);
        nx();
        flush_ack = 1'b0;
        smp();
        chk("pri_exc_mcause", csr_wr_mcause, 32'h2);
        chk("pri_exc_mepc", csr_wr_mepc, 32'h600);
        nx();
        smp();
        chk("pri_idle", 32'(flush_req), 32'h0);
        nx();
        valid = 1'b0; std_irq = '0; flush_ack = 1'b1;
        smp();
        chk("pri_irq_flush", 32'(flush_req), 32'h1);
        nx();
        flush_ack = 1'b0;
        smp();
        chk("pri_irq_mcause", csr_wr_mcause, 32'h8000000B);
        chk("pri_irq_mepc", csr_wr_mepc, 32'h604);
        chk("pri_irq_trap_pc", trap_pc, 32'h82C);
        nx();

        // Flush held off, then reset aborts the pending trap.
        valid = 1'b1; exc_pending = 1'b1; exc_code = 4'd4; pc = 32'h700;
        nx();
        valid = 1'b0; exc_pending = 1'b0;
        for (int k = 0; k < 5; k++) begin
            smp();
            chk($sformatf("hold%0d_flush_req", k), 32'(flush_req), 32'h1);
            chk($sformatf("hold%0d_trap", k), 32'(trap), 32'h0);
            nx();
        end
        rst_b = 1'b0;
        #1;
        chk("abort_flush_req", 32'(flush_req), 32'h0);
        flush_ack = 1'b1;
        nx();
        rst_b = 1'b1;
        for (int k = 0; k < 3; k++) begin
            smp();
            chk($sformatf("abort%0d_trap", k), 32'(trap), 32'h0);
            chk($sformatf("abort%0d_ent", k), 32'(ent_trap), 32'h0);
            chk($sformatf("abort%0d_flush", k), 32'(flush_req), 32'h0);
            nx();
        end
        flush_ack = 1'b0;

        // Pending bit layout; no interrupt while mstatus.mie=0.
        csr_rd_mstatus = 2'b00; std_irq = 3'b101; local_irq = 4'b0001;
        nx();
        smp();
        chk("mip_layout", 32'(csr_mip), 32'h10808);
        valid = 1'b1;
        nx();
        smp();
        chk("mie_off_no_flush", 32'(flush_req), 32'h0);
        valid = 1'b0; std_irq = '0; local_irq = '0;
        nx();

`ifdef TRAP_WFI_EN
        csr_rd_mstatus = 2'b01; csr_rd_mie = 20'hFFFFF;
        csr_rd_mtvec = 32'h801;
        valid = 1'b1; wfi = 1'b1; pc = 32'h40;
        nx();
        valid = 1'b0; wfi = 1'b0;
        smp();
        chk("wfi_stall", 32'(stall), 32'h1);
        chk("wfi_no_flush", 32'(flush_req), 32'h0);
        local_irq = 4'b0100;
        nx();
        smp();
        chk("wfi_stall_hold", 32'(stall), 32'h1);
        nx();
        smp();
        chk("wfi_stall_drop", 32'(stall), 32'h0);
        chk("wfi_flush_req", 32'(flush_req), 32'h1);
        flush_ack = 1'b1;
        nx();
        flush_ack = 1'b0; local_irq = '0;
        smp();
        chk("wfi_mcause", csr_wr_mcause, 32'h80000012);
        chk("wfi_mepc", csr_wr_mepc, 32'h44);
        chk("wfi_trap_pc", trap_pc, 32'h848);
        nx();
`else
        csr_rd_mstatus = 2'b01;
        valid = 1'b1; wfi = 1'b1; pc = 32'h40;
        nx();
        valid = 1'b0; wfi = 1'b0;
        smp();
        chk("wfi_nop_stall", 32'(stall), 32'h0);
        chk("wfi_nop_flush", 32'(flush_req), 32'h0);
        nx();
        smp();
        chk("wfi_nop_trap", 32'(trap), 32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
